// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared state encoding and limits for the mem_resp responder
package mem_resp_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RD_LAT_MAX = 8;

endpackage

// File: rtl/mem_resp_rdpipe.sv
// rtl/mem_resp_rdpipe.sv - LAT-stage valid/data shift pipeline with synchronous clear
module mem_resp_rdpipe
  import mem_resp_pkg::*;
#(
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data
);

  logic [LAT-1:0]         vld_q, vld_d;
  logic [LAT-1:0][DW-1:0] data_q, data_d;

  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[LAT-1];
  assign out_data = data_q[LAT-1];

endmodule

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - fill-on-reset memory responder with fixed read latency
// MEM_RESP_INCR_FILL_EN: fill word i with BASE+i instead of 0 during INIT.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int                MEM_AW     = 16,
  parameter int                MEM_DW     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [MEM_AW-1:0] BASE       = 'h0,
  parameter int                RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  output logic              init_done,
  output logic              acc_err
);

  localparam int              DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [MEM_AW:0] BASE_X  = {1'b0, BASE};
  localparam logic [MEM_AW:0] LIMIT_X = BASE_X + (MEM_AW+1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   fill_idx_q, fill_idx_d;
  logic                    init_done_q, init_done_d;
  logic                    acc_err_q, acc_err_d;
  logic [MEM_DW-1:0]       mem_q [DEPTH];

  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_widx;
  logic [MEM_DW-1:0]       mem_wdat;
  logic [MEM_DW-1:0]       fill_data;
  logic                    rd_vld;
  logic [MEM_DW-1:0]       rd_data;

`ifdef MEM_RESP_INCR_FILL_EN
  logic [MEM_AW-1:0] fill_addr;
  assign fill_addr = BASE + MEM_AW'(fill_idx_q);
  assign fill_data = MEM_DW'(fill_addr);
`else
  assign fill_data = '0;
`endif

  // Compare one bit wider so BASE+DEPTH never wraps past the top of the address space.
  assign in_range = ({1'b0, mem_addr} >= BASE_X) && ({1'b0, mem_addr} < LIMIT_X);
  assign req_idx  = mem_addr[DEPTH_LOG2-1:0] - BASE[DEPTH_LOG2-1:0];

  always_comb begin
    state_d     = state_q;
    fill_idx_d  = fill_idx_q;
    init_done_d = init_done_q;
    acc_err_d   = acc_err_q;
    mem_we      = 1'b0;
    mem_widx    = req_idx;
    mem_wdat    = mem_wdata;
    rd_vld      = 1'b0;
    rd_data     = '0;
    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_widx   = fill_idx_q;
        mem_wdat   = fill_data;
        fill_idx_d = fill_idx_q + 1'b1;
        if (mem_req) acc_err_d = 1'b1;
        if (&fill_idx_q) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end
      end
      READY: begin
        if (mem_req) begin
          if (!in_range) acc_err_d = 1'b1;
          if (mem_write) begin
            mem_we = in_range;
          end else begin
            rd_vld  = 1'b1;
            rd_data = in_range ? mem_q[req_idx] : '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      fill_idx_q  <= '0;
      init_done_q <= 1'b0;
      acc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_idx_q  <= fill_idx_d;
      init_done_q <= init_done_d;
      acc_err_q   <= acc_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_widx] <= mem_wdat;
  end

  mem_resp_rdpipe #(
    .DW  (MEM_DW),
    .LAT (RD_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .clr      (rst),
    .in_vld   (rd_vld),
    .in_data  (rd_data),
    .out_vld  (mem_rdata_vld),
    .out_data (mem_rdata)
  );

  assign init_done = init_done_q;
  assign acc_err   = acc_err_q;

endmodule
